// File: rtl/signal_gen.sv
// rtl/signal_gen.sv - programmable period/high-time waveform generator with double-buffered configuration
module signal_gen #(
    parameter int COUNTER_MAX = 100000,
    parameter int PERIOD_MIN  = 2
) (
    input  logic        clk,
    input  logic        as_reset,
    input  logic        enable,
    input  logic        load,
    input  logic [19:0] period_in,
    input  logic [19:0] high_in,
    output logic        signal_out,
    output logic        load_ack,
    output logic        load_err,
    output logic        period_done,
    output logic        running
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [19:0] P_MAX = 20'(COUNTER_MAX);
    localparam logic [19:0] P_MIN = 20'(PERIOD_MIN);

    state_t      state, state_next;
    logic [19:0] cnt, cnt_next;
    logic [19:0] act_p, act_h, pend_p, pend_h, new_h;
    logic        pend_valid, cfg_valid;
    logic        sig_next, load_ok, at_wrap, xfer;

    assign load_ok     = (period_in >= P_MIN) && (period_in <= P_MAX);
    assign at_wrap     = (state != IDLE) && (cnt >= act_p - 20'd1);
    assign xfer        = pend_valid && ((state == IDLE) || at_wrap);
    assign new_h       = xfer ? pend_h : act_h;
    assign period_done = at_wrap;
    assign running     = (state != IDLE);

    always_comb begin
        state_next = state;
        cnt_next   = '0;
        sig_next   = 1'b0;
        case (state)
            IDLE: begin
                if (enable && (cfg_valid || pend_valid)) begin
                    state_next = RUN;
                    sig_next   = (new_h != '0);
                end
            end
            RUN, DRAIN: begin
                if (at_wrap) begin
                    // Enable seen at the wrap continues seamlessly; otherwise the period is done
                    if (enable) begin
                        state_next = RUN;
                        sig_next   = (new_h != '0);
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    state_next = enable ? RUN : DRAIN;
                    cnt_next   = cnt + 20'd1;
                    sig_next   = ((cnt + 20'd1) < act_h);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge as_reset) begin
        if (as_reset) begin
            state      <= IDLE;
            cnt        <= '0;
            signal_out <= 1'b0;
            load_ack   <= 1'b0;
            load_err   <= 1'b0;
            act_p      <= '0;
            act_h      <= '0;
            pend_p     <= '0;
            pend_h     <= '0;
            pend_valid <= 1'b0;
            cfg_valid  <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            signal_out <= sig_next;
            load_ack   <= load && load_ok;
            load_err   <= load && !load_ok;
            if (xfer) begin
                act_p     <= pend_p;
                act_h     <= pend_h;
                cfg_valid <= 1'b1;
            end
            // A load coinciding with a transfer becomes the next pending value
            if (load && load_ok) begin
                pend_p     <= period_in;
                pend_h     <= (high_in > period_in) ? period_in : high_in;
                pend_valid <= 1'b1;
            end else if (xfer) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/signal_gen.md
SIGNAL_GEN -- requirements
Module: signal_gen

Interface
REQ-001 Parameter COUNTER_MAX, default 100000, is the largest accepted period in clock cycles.
REQ-002 Parameter PERIOD_MIN, default 2, is the smallest accepted period in clock cycles.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 as_reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  run request; level-sensitive.
REQ-006 load  input  1  one-cycle strobe qualifying period_in and high_in.
REQ-007 period_in  input  20  requested period P in clock cycles.
REQ-008 high_in  input  20  requested high time H in clock cycles.
REQ-009 signal_out  output  1  generated waveform; driven directly from a flop.
REQ-010 load_ack  output  1  one-cycle pulse, configuration accepted.
REQ-011 load_err  output  1  one-cycle pulse, configuration rejected.
REQ-012 period_done  output  1  one-cycle pulse on the last cycle of each period.
REQ-013 running  output  1  high when the FSM is in RUN or DRAIN.

Function
REQ-014 The block SHALL hold active registers act_p and act_h, pending registers pend_p, pend_h and pend_valid, a cfg_valid flag, and a 20-bit phase counter cnt.
REQ-015 On load with PERIOD_MIN <= period_in <= COUNTER_MAX, the block SHALL capture the values into the pending registers, set pend_valid, and assert load_ack in the next cycle.
REQ-016 On load with period_in outside that range, the block SHALL leave all configuration registers unchanged and assert load_err in the next cycle.
REQ-017 If high_in > period_in on an accepted load, the block SHALL store H = period_in (constant high); H = 0 SHALL be accepted (constant low).
REQ-018 A load in the same cycle as a pending-to-active transfer SHALL be captured as the new pending value; it SHALL NOT be lost.
REQ-019 A second load before transfer SHALL overwrite the pending values (last write wins).
REQ-020 The FSM SHALL have states IDLE, RUN and DRAIN.
REQ-021 In IDLE: cnt = 0, signal_out = 0, and any pending configuration SHALL transfer to active on the next clock, setting cfg_valid.
REQ-022 IDLE -> RUN when enable = 1 and cfg_valid = 1 (or pend_valid = 1, transferred in the same cycle); otherwise the FSM SHALL stay in IDLE.
REQ-023 In RUN/DRAIN, cnt SHALL count 0..act_p-1, and signal_out for phase k SHALL be 1 iff k < act_h.
REQ-024 Latency: the first high cycle of signal_out SHALL be the cycle after enable is sampled high in IDLE.
REQ-025 At cnt = act_p-1, period_done SHALL pulse, cnt SHALL wrap to 0, and pend_valid set SHALL transfer pending to active, so new P/H apply from phase 0 of the next period only.
REQ-026 RUN -> DRAIN when enable = 0; the current period SHALL complete, then DRAIN -> IDLE at the wrap.
REQ-027 DRAIN -> RUN if enable returns to 1 before the wrap, with no gap in the waveform.
REQ-028 The rising-edge-to-rising-edge interval of signal_out SHALL be exactly act_p cycles whenever 0 < act_h < act_p.
REQ-029 cnt SHALL never exceed COUNTER_MAX-1.

Reset
REQ-030 While as_reset = 1: FSM = IDLE, cnt = 0, act/pend registers = 0, cfg_valid = 0, pend_valid = 0, and all outputs = 0, independent of clk.
REQ-031 Reset asserted mid-period SHALL force signal_out low immediately; after release the block SHALL stay idle until a new valid load.

Verification
REQ-032 Load P=10, H=3, enable=1 -> signal_out repeats 3 high / 7 low; period_done every 10 cycles; load_ack 1 cycle after load.
REQ-033 Load P=1, then P=100001 -> load_err pulses each time, no change in output; load P=2, H=5 -> 2-cycle constant high.
REQ-034 While running P=10, H=3, load P=6, H=1 at phase 4 -> current period completes as 10/3; the next period is 6/1.
REQ-035 Drop enable at phase 2 of P=8, H=4 -> period finishes, running falls after period_done, signal_out = 0 thereafter.
REQ-036 Assert as_reset at phase 1 (high) -> signal_out = 0 asynchronously; after release with enable = 1 and no load, the output stays 0.
REQ-037 H = 0 with P = 5 -> signal_out constantly 0 while period_done still pulses every 5 cycles.
